// File: rtl/mul8x1_mux.sv
// 8-to-1 single-bit mux: F = {D7..D0}[addr]. Registered (1-cycle latency, async clear) when REG_OUT=1,
// purely combinational when REG_OUT=0. No handshake; F follows the inputs every cycle.
module mul8x1_mux #(
  parameter int unsigned REG_OUT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       D0,
  input  logic       D1,
  input  logic       D2,
  input  logic       D3,
  input  logic       D4,
  input  logic       D5,
  input  logic       D6,
  input  logic       D7,
  input  logic [2:0] addr,
  output logic       F
);

  logic [7:0] data;
  logic       sel;

  assign data = {D7, D6, D5, D4, D3, D2, D1, D0};
  assign sel  = data[addr];

  generate
    if (REG_OUT != 0) begin : g_reg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          F <= 1'b0;
        end else begin
          F <= sel;
        end
      end
    end else begin : g_comb
      // clk and rst_n have no role in this build; fold them into a sink net.
      logic unused_clk_rst;
      assign unused_clk_rst = &{1'b0, clk, rst_n};
      assign F = sel;
    end
  endgenerate

endmodule

// File: tb/tb_mul8x1_mux.sv
// Scoreboard bench for mul8x1_mux: registered build checked through an expected-value queue,
// combinational build checked directly.
module tb_mul8x1_mux;

  logic       clk;
  logic       rst_n;
  logic [7:0] d;
  logic [2:0] addr;
  logic       f;

  logic       c_rst_n;
  logic [7:0] c_d;
  logic [2:0] c_addr;
  logic       c_f;

  int total = 0;
  int bad   = 0;

  bit         exp_q[$];
  logic [10:0] info_q[$];

  mul8x1_mux #(.REG_OUT(1)) u_reg (
    .clk(clk), .rst_n(rst_n),
    .D0(d[0]), .D1(d[1]), .D2(d[2]), .D3(d[3]),
    .D4(d[4]), .D5(d[5]), .D6(d[6]), .D7(d[7]),
    .addr(addr), .F(f)
  );

  mul8x1_mux #(.REG_OUT(0)) u_comb (
    .clk(clk), .rst_n(c_rst_n),
    .D0(c_d[0]), .D1(c_d[1]), .D2(c_d[2]), .D3(c_d[3]),
    .D4(c_d[4]), .D5(c_d[5]), .D6(c_d[6]), .D7(c_d[7]),
    .addr(c_addr), .F(c_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit model(input logic [7:0] dv, input logic [2:0] av);
    int unsigned idx;
    idx = av;
    return ((dv >> idx) & 8'd1) != 0;
  endfunction

  task automatic check(input string name, input logic got, input logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: F=%b expected=%b at t=%0t", name, got, want, $time);
    end
  endtask

  task automatic step(input logic [7:0] dv, input logic [2:0] av);
    @(negedge clk);
    d    = dv;
    addr = av;
    exp_q.push_back(model(dv, av));
    info_q.push_back({dv, av});
  endtask

  // Monitor: every rising edge with a pending expectation presents one result.
  initial begin
    bit          e;
    logic [10:0] inf;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        inf = info_q.pop_front();
        total++;
        if (f !== e) begin
          bad++;
          $display("FAIL reg_sel d=%h addr=%0d: F=%b expected=%b at t=%0t",
                   inf[10:3], inf[2:0], f, e, $time);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned order [8] = '{0, 1, 3, 2, 6, 7, 5, 4};
    logic [7:0] one;
    rst_n   = 1'b0;
    d       = 8'hFF;
    addr    = 3'd0;
    c_rst_n = 1'b1;
    c_d     = 8'h00;
    c_addr  = 3'd0;
    one     = 8'd1;

    // Reset held: F stays 0 across edges despite D0=1.
    #1 check("reset_async", f, 1'b0);
    repeat (2) begin
      @(posedge clk); #1;
      check("reset_hold", f, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(1'b1);
    info_q.push_back({8'hFF, 3'd0});

    // Walking one on addr 0.
    step(8'h00, 3'd0);
    step(8'h01, 3'd0);
    step(8'h00, 3'd0);

    // Address sweep: selected bit pulses through, every other bit is ignored.
    foreach (order[i]) begin
      step(8'h00, order[i][2:0]);
      step(one << order[i], order[i][2:0]);
      step(8'h00, order[i][2:0]);
      for (int b = 0; b < 8; b++)
        if (b != int'(order[i])) step(one << b, order[i][2:0]);
    end

    // Isolation.
    step(8'b1101_1111, 3'b101);
    step(8'b0010_0000, 3'b101);

    // Mid-operation reset, asserted between edges.
    step(8'h80, 3'd7);
    step(8'h80, 3'd7);
    @(posedge clk); #2;
    check("pre_reset_high", f, 1'b1);
    rst_n = 1'b0;
    #1 check("midop_reset_async", f, 1'b0);
    repeat (2) begin
      @(posedge clk); #1;
      check("midop_reset_hold", f, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic, addr and D changing together.
    for (int n = 0; n < 300; n++)
      step(8'($urandom), 3'($urandom_range(7, 0)));

    @(posedge clk); #3;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: pending=%0d expected=0", exp_q.size());
    end

    // Combinational build.
    #2;
    c_addr = 3'b010;
    c_d    = 8'h00;
    #1 check("comb_d2_low", c_f, 1'b0);
    c_d[2] = 1'b1;
    #1 check("comb_d2_high", c_f, 1'b1);
    c_rst_n = 1'b0;
    #1 check("comb_rst_ignored_hi", c_f, 1'b1);
    c_d[2] = 1'b0;
    #1 check("comb_rst_ignored_lo", c_f, 1'b0);
    c_rst_n = 1'b1;
    c_d     = 8'b1111_1011;
    #1 check("comb_isolation", c_f, 1'b0);
    for (int n = 0; n < 100; n++) begin
      c_d    = 8'($urandom);
      c_addr = 3'($urandom_range(7, 0));
      c_rst_n = 1'($urandom);
      #1 check("comb_rand", c_f, model(c_d, c_addr));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
